// File: rtl/crossbar_pkg.sv
// Shared definitions for the 4x4 crossbar scheduler.
//   N_PORTS        number of crossbar inputs/outputs (fixed at 4)
//   SEL_W          select width per output, log2(N_PORTS)
//   MAX_BEATS_DEF  default beat limit before a grant is force-released
//   xsch_state_t   per-output lock state
//   port_idx_t     index of one crossbar port
package crossbar_pkg;

    localparam int N_PORTS       = 4;
    localparam int SEL_W         = 2;
    localparam int MAX_BEATS_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } xsch_state_t;

    typedef logic [SEL_W-1:0] port_idx_t;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter.
//   req  in   4  request vector
//   ptr  in   2  index of the most recent winner; search starts just after it
//   gnt  out  4  one-hot grant (all zero when nothing requests)
//   idx  out  2  index of the granted requester (ptr when nothing requests)
module rr_arb4
    import crossbar_pkg::*;
(
    input  logic [3:0] req,
    input  port_idx_t  ptr,
    output logic [3:0] gnt,
    output port_idx_t  idx
);

    port_idx_t cand;
    logic      found;

    // Visit ptr+1, ptr+2, ptr+3 and finally ptr itself; the 2-bit add wraps.
    always_comb begin
        gnt   = '0;
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int o = 1; o <= 4; o++) begin
            cand = ptr + port_idx_t'(o);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbar_rr_scheduler.sv
// Scheduler for the 4x4 crossbar. Every output has its own round-robin
// arbiter and holds its grant until the packet's last beat has moved, or
// until MAX_BEATS beats have moved without a last (forced release).
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   4   requester i has a beat pending
//   in_dest    in   8   [2i+1:2i] = target output of requester i
//   in_last    in   4   current beat of requester i ends its packet
//   in_ready   out  4   beat of requester i is accepted this cycle
//   out_ready  in   4   sink of output k accepts a beat
//   out_valid  out  4   output k carries a valid beat
//   xbar_ctrl  out  16  [2k+1:2k] = input routed to output k; [15:8] = 0
//   busy       out  4   output k is locked to a requester (exposes FSM state)
//   to_pulse   out  4   one-cycle pulse: output k released by the beat limit
//
// Handshake: a beat moves on output k in any cycle where busy[k],
// in_valid[owner_k] and out_ready[k] are all high; in_ready/out_valid are
// the two halves of that same condition seen from each side.
module crossbar_rr_scheduler
    import crossbar_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_valid,
    input  logic [7:0]  in_dest,
    input  logic [3:0]  in_last,
    output logic [3:0]  in_ready,
    input  logic [3:0]  out_ready,
    output logic [3:0]  out_valid,
    output logic [15:0] xbar_ctrl,
    output logic [3:0]  busy,
    output logic [3:0]  to_pulse
);

    localparam int CNT_W = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);

    xsch_state_t      state_q [N_PORTS];
    xsch_state_t      state_d [N_PORTS];
    port_idx_t        owner_q [N_PORTS];
    port_idx_t        owner_d [N_PORTS];
    port_idx_t        ptr_q   [N_PORTS];
    port_idx_t        ptr_d   [N_PORTS];
    logic [CNT_W-1:0] cnt_q   [N_PORTS];
    logic [CNT_W-1:0] cnt_d   [N_PORTS];
    logic [3:0]       pulse_q;
    logic [3:0]       pulse_d;

    logic [3:0]       req     [N_PORTS];
    logic [3:0]       gnt     [N_PORTS];
    port_idx_t        win     [N_PORTS];

    // Request matrix: requester i wants output k when valid and aimed at k.
    always_comb begin
        for (int k = 0; k < N_PORTS; k++) begin
            req[k] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                req[k][i] = in_valid[i] && (in_dest[2*i +: 2] == port_idx_t'(k));
            end
        end
    end

    for (genvar k = 0; k < N_PORTS; k++) begin : g_arb
        rr_arb4 u_arb (
            .req (req[k]),
            .ptr (ptr_q[k]),
            .gnt (gnt[k]),
            .idx (win[k])
        );
    end

    // Outputs follow the latched owner only; in_dest is ignored while locked.
    always_comb begin
        busy      = '0;
        out_valid = '0;
        in_ready  = '0;
        xbar_ctrl = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            busy[k]            = (state_q[k] == BUSY);
            xbar_ctrl[2*k +: 2] = owner_q[k];
            if (state_q[k] == BUSY) begin
                out_valid[k]          = in_valid[owner_q[k]];
                in_ready[owner_q[k]] = in_ready[owner_q[k]] | out_ready[k];
            end
        end
    end

    assign to_pulse = pulse_q;

    // Per-output next state. A last beat wins over the beat limit, so a
    // packet ending exactly on the limit is a normal release without a pulse.
    always_comb begin
        pulse_d = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            state_d[k] = state_q[k];
            owner_d[k] = owner_q[k];
            ptr_d[k]   = ptr_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                IDLE: begin
                    if (|gnt[k]) begin
                        state_d[k] = BUSY;
                        owner_d[k] = win[k];
                        ptr_d[k]   = win[k];
                        cnt_d[k]   = '0;
                    end
                end
                BUSY: begin
                    if (out_valid[k] && out_ready[k]) begin
                        if (in_last[owner_q[k]]) begin
                            state_d[k] = IDLE;
                        end else if (MAX_BEATS != 0 && cnt_q[k] == CNT_LAST) begin
                            state_d[k] = IDLE;
                            pulse_d[k] = 1'b1;
                        end
                        if (cnt_q[k] != CNT_SAT) begin
                            cnt_d[k] = cnt_q[k] + 1'b1;
                        end
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

    // Pointers reset to 3 so that input 0 is the first one searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
            for (int k = 0; k < N_PORTS; k++) begin
                state_q[k] <= IDLE;
                owner_q[k] <= '0;
                ptr_q[k]   <= 2'd3;
                cnt_q[k]   <= '0;
            end
        end else begin
            pulse_q <= pulse_d;
            for (int k = 0; k < N_PORTS; k++) begin
                state_q[k] <= state_d[k];
                owner_q[k] <= owner_d[k];
                ptr_q[k]   <= ptr_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_crossbar_rr_scheduler.sv
// Self-checking bench for crossbar_rr_scheduler. Vectors are one cycle each:
// inputs driven just after the rising edge, outputs compared at the falling
// edge of the same cycle. Observed word = {busy, in_ready, out_valid,
// xbar_ctrl, to_pulse}.
module tb_crossbar_rr_scheduler;
    import crossbar_pkg::*;

    localparam int W = 32;

    typedef struct {
        string        name;
        logic [3:0]   iv;
        logic [7:0]   dst;
        logic [3:0]   il;
        logic [3:0]   ordy;
        logic [W-1:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [7:0]  in_dest;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [3:0]  out_ready;
    logic [3:0]  out_valid;
    logic [15:0] xbar_ctrl;
    logic [3:0]  busy;
    logic [3:0]  to_pulse;

    int           n_cmp;
    int           n_bad;
    logic [W-1:0] exp_q[$];
    vec_t         vecs[$];

    crossbar_rr_scheduler #(.MAX_BEATS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_dest   (in_dest),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .xbar_ctrl (xbar_ctrl),
        .busy      (busy),
        .to_pulse  (to_pulse)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        in_valid  = '0;
        in_dest   = '0;
        in_last   = '0;
        out_ready = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pk(logic [3:0] b, logic [3:0] r, logic [3:0] v,
                                        logic [7:0] c, logic [3:0] p);
        return {b, r, v, 8'h00, c, p};
    endfunction

    function automatic vec_t mk(string n, logic [3:0] iv, logic [7:0] d, logic [3:0] il,
                                logic [3:0] o, logic [W-1:0] e);
        vec_t r;
        r.name = n;
        r.iv   = iv;
        r.dst  = d;
        r.il   = il;
        r.ordy = o;
        r.exp  = e;
        return r;
    endfunction

    function automatic logic [W-1:0] observed();
        return {busy, in_ready, out_valid, xbar_ctrl, to_pulse};
    endfunction

    task automatic check(string n, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic run_vecs();
        for (int t = 0; t < vecs.size(); t++) begin
            @(posedge clk);
            #1;
            in_valid  = vecs[t].iv;
            in_dest   = vecs[t].dst;
            in_last   = vecs[t].il;
            out_ready = vecs[t].ordy;
            exp_q.push_back(vecs[t].exp);
            @(negedge clk);
            check($sformatf("%s[%0d]", vecs[t].name, t), observed(), exp_q.pop_front());
        end
        vecs.delete();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // ---------------- test ----------------
    initial begin
        int seq [5];
        int own;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive_idle();

        // Reset held with random inputs: everything stays quiet.
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            in_valid  = 4'($urandom_range(0, 15));
            in_dest   = 8'($urandom_range(0, 255));
            in_last   = 4'($urandom_range(0, 15));
            out_ready = 4'($urandom_range(0, 15));
            @(negedge clk);
            check($sformatf("reset[%0d]", t), observed(), pk(4'h0, 4'h0, 4'h0, 8'h00, 4'h0));
        end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat from input 0 to output 2.
        vecs.push_back(mk("single", 4'b0001, 8'h02, 4'b0001, 4'hF, pk(4'h0, 4'h0, 4'h0, 8'h00, 4'h0)));
        vecs.push_back(mk("single", 4'b0001, 8'h02, 4'b0001, 4'hF, pk(4'b0100, 4'b0001, 4'b0100, 8'h00, 4'h0)));
        vecs.push_back(mk("single", 4'b0000, 8'h02, 4'b0000, 4'hF, pk(4'h0, 4'h0, 4'h0, 8'h00, 4'h0)));
        run_vecs();

        // Four inputs to four different outputs arbitrate independently.
        do_reset();
        vecs.push_back(mk("indep", 4'hF, 8'hE4, 4'hF, 4'hF, pk(4'h0, 4'h0, 4'h0, 8'h00, 4'h0)));
        vecs.push_back(mk("indep", 4'hF, 8'hE4, 4'hF, 4'hF, pk(4'hF, 4'hF, 4'hF, 8'hE4, 4'h0)));
        vecs.push_back(mk("indep", 4'h0, 8'hE4, 4'h0, 4'hF, pk(4'h0, 4'h0, 4'h0, 8'hE4, 4'h0)));
        run_vecs();

        // Contention: inputs 0,1,3 send single-beat packets to output 1.
        do_reset();
        seq[0] = 0; seq[1] = 1; seq[2] = 3; seq[3] = 0; seq[4] = 1;
        for (int t = 0; t < 10; t++) begin
            if (t % 2 == 1) begin
                own = seq[t / 2];
                vecs.push_back(mk("contend", 4'b1011, 8'h45, 4'b1011, 4'hF,
                    pk(4'b0010, 4'(1 << own), 4'b0010, 8'(own << 2), 4'h0)));
            end else begin
                own = (t == 0) ? 0 : seq[(t - 1) / 2];
                vecs.push_back(mk("contend", 4'b1011, 8'h45, 4'b1011, 4'hF,
                    pk(4'h0, 4'h0, 4'h0, 8'(own << 2), 4'h0)));
            end
        end
        run_vecs();

        // Lock: 4-beat packet from input 2 to output 0, out_ready[0] toggling;
        // input 1 waits for output 0 from cycle 1.
        do_reset();
        for (int t = 0; t <= 10; t++) begin
            logic [3:0]   iv;
            logic [3:0]   il;
            logic [3:0]   o;
            logic [W-1:0] e;
            iv = (t == 0) ? 4'b0100 : (t <= 8) ? 4'b0110 : 4'b0010;
            il = (t == 8) ? 4'b0110 : 4'b0010;
            o  = {3'b111, (t % 2 == 0)};
            if (t == 0)
                e = pk(4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
            else if (t <= 8)
                e = pk(4'b0001, (t % 2 == 0) ? 4'b0100 : 4'b0000, 4'b0001, 8'h02, 4'h0);
            else if (t == 9)
                e = pk(4'h0, 4'h0, 4'h0, 8'h02, 4'h0);
            else
                e = pk(4'b0001, 4'b0010, 4'b0001, 8'h01, 4'h0);
            vecs.push_back(mk("lock", iv, 8'h00, il, o, e));
        end
        run_vecs();

        // Beat limit: input 3 streams to output 2 without last, input 0 waits.
        do_reset();
        for (int t = 0; t <= 18; t++) begin
            logic [W-1:0] e;
            if (t == 0)
                e = pk(4'h0, 4'h0, 4'h0, 8'h00, 4'h0);
            else if (t <= 16)
                e = pk(4'b0100, 4'b1000, 4'b0100, 8'h30, 4'h0);
            else if (t == 17)
                e = pk(4'h0, 4'h0, 4'h0, 8'h30, 4'b0100);
            else
                e = pk(4'b0100, 4'b0001, 4'b0100, 8'h00, 4'h0);
            vecs.push_back(mk("timeout", (t == 0) ? 4'b1000 : 4'b1001, 8'h82, 4'h0, 4'hF, e));
        end
        run_vecs();

        // Mid-packet reset: 4-beat packet from input 2 to output 3.
        do_reset();
        @(posedge clk);
        #1;
        in_valid  = 4'b0100;
        in_dest   = 8'h30;
        in_last   = 4'h0;
        out_ready = 4'hF;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_lock", observed(), pk(4'b1000, 4'b0100, 4'b1000, 8'h80, 4'h0));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_async", observed(), pk(4'h0, 4'h0, 4'h0, 8'h00, 4'h0));
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b0111;
        in_dest   = 8'h3F;
        in_last   = 4'b0111;
        @(negedge clk);
        check("midrst_regrant", observed(), pk(4'b1000, 4'b0001, 4'b1000, 8'h00, 4'h0));
        drive_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
